// File: rtl/register_serializer.sv
// ---------------------------------------------------------------------------
// RegisterSerializer
//
// Takes a WIDTH-bit parallel word and sends it out one bit per accepted
// handshake, most significant bit first. The receiver paces the transfer
// with bit_ack, and the sender waits as long as needed. After the last bit
// is accepted, done pulses for one cycle. The block then goes back to
// idle and can take a new word.
//
// Ports
//   clk      : single clock, rising-edge active
//   reset    : asynchronous, active-high reset
//   in       : parallel word, captured on an accepted load
//   load     : capture request, honoured only while ready is high
//   bit_ack  : receiver accepts the bit currently on serial
//   ready    : a new word can be accepted (idle)
//   valid    : serial carries a data bit
//   serial   : current data bit, MSB first
//   last     : serial carries bit 0, the final bit of the word
//   done     : one-cycle pulse after the final bit is accepted
//
// WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module register_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             bit_ack,
    output logic             ready,
    output logic             valid,
    output logic             serial,
    output logic             last,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;

    logic w_isLast;
    logic w_capture;
    logic w_advance;

    // Control qualifiers. Load and bit_ack only matter in their own state.
    // In every other state they have no effect.
    assign w_isLast  = (r_state == SHIFT) && (r_count == LAST_IDX);
    assign w_capture = (r_state == IDLE)  && load;
    assign w_advance = (r_state == SHIFT) && bit_ack;

    // State register. Reset takes effect immediately, so every decoded
    // output falls back to its idle value without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE lasts exactly one cycle, and the FSM then
    // returns to idle whatever the inputs are.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_ack && w_isLast) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. The shift register moves left by one on each accepted bit,
    // so the bit on the wire is always the MSB. After the final bit the
    // counter clears instead of wrapping into a phantom extra bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_capture) begin
            r_shift <= in;
            r_count <= '0;
        end else if (w_advance) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_count <= w_isLast ? '0 : r_count + CW'(1);
        end
    end

    // Outputs depend only on registered state. No input reaches an output
    // in the same cycle.
    assign ready  = (r_state == IDLE);
    assign valid  = (r_state == SHIFT);
    assign serial = (r_state == SHIFT) && r_shift[WIDTH-1];
    assign last   = w_isLast;
    assign done   = (r_state == DONE);

endmodule

// File: tb/tb_register_serializer.sv
// ---------------------------------------------------------------------------
// tb_register_serializer
//
// Directed bench for register_serializer at WIDTH=16. Each scenario drives
// a word and compares the outputs against hand-derived bit patterns, one
// cycle at a time.
// ---------------------------------------------------------------------------
module tb_register_serializer;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        bit_ack;
    logic        ready;
    logic        valid;
    logic        serial;
    logic        last;
    logic        done;

    int vecCount = 0;
    int errCount = 0;

    register_serializer #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .load    (load),
        .bit_ack (bit_ack),
        .ready   (ready),
        .valid   (valid),
        .serial  (serial),
        .last    (last),
        .done    (done)
    );

    // 10 ns clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] word, input logic ack);
        load    = ld;
        in      = word;
        bit_ack = ack;
    endtask

    // Move to 1 ns after the next rising edge. Stimulus and sampling both
    // happen there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : mainSeq
        logic [15:0] expBits;
        int          idx;

        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // Async reset with no clock edge. The idle outputs must appear at once.
        #1 reset = 1'b1;
        #1;
        checkOutput("reset idle", {ready, valid, serial, last, done}, 5'b10000);
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("post-reset idle", {ready, valid, serial, last, done}, 5'b10000);

        // 0xA5C3 with bit_ack held high: one bit per cycle, done at +16.
        expBits = 16'b1010_0101_1100_0011;
        applyStimulus(1'b1, 16'hA5C3, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("a5c3 bit%0d", i), {ready, valid, serial, last, done},
                        {1'b0, 1'b1, expBits[15-i], (i == 15), 1'b0});
            step();
        end
        checkOutput("a5c3 done", {ready, valid, serial, last, done}, 5'b00001);
        step();
        checkOutput("a5c3 ready", {ready, valid, serial, last, done}, 5'b10000);

        // 0x8001 with bit_ack alternating 0,1: each bit holds two cycles,
        // done at +32.
        expBits = 16'h8001;
        applyStimulus(1'b1, 16'h8001, 1'b0);
        step();
        for (int c = 0; c < 32; c++) begin
            applyStimulus(1'b0, 16'h0000, (c % 2) == 1);
            idx = 15 - c / 2;
            checkOutput($sformatf("8001 cyc%0d", c), {valid, serial, last, done},
                        {1'b1, expBits[idx], (c >= 30), 1'b0});
            step();
        end
        checkOutput("8001 done@32", {valid, done}, 2'b01);
        step();
        checkOutput("8001 ready", {ready, done}, 2'b10);

        // 0x0000 with a 0xFFFF load attempted mid-shift: the load is
        // ignored and all bits are zero.
        applyStimulus(1'b1, 16'h0000, 1'b1);
        step();
        for (int i = 0; i < 16; i++) begin
            if (i >= 2 && i < 10) applyStimulus(1'b1, 16'hFFFF, 1'b1);
            else                  applyStimulus(1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("zero bit%0d", i), {ready, valid, serial}, 3'b010);
            step();
        end
        checkOutput("zero done", {ready, done}, 2'b01);
        step();
        checkOutput("zero ready", {ready, done}, 2'b10);

        // 0xFFFF aborted by an async reset after 5 bits.
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("ffff bit%0d", i), {valid, serial}, 2'b11);
            step();
        end
        #3 reset = 1'b1;
        #1;
        checkOutput("abort immediate", {ready, valid, serial, last, done}, 5'b10000);
        applyStimulus(1'b1, 16'h5555, 1'b1);
        step();
        checkOutput("reset ignores load", {ready, valid, serial, last, done}, 5'b10000);
        step();
        checkOutput("reset holds idle", {ready, valid, serial, last, done}, 5'b10000);
        #2 reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        step();
        checkOutput("no done after abort", {ready, valid, serial, last, done}, 5'b10000);
        step();
        checkOutput("still idle", {ready, valid, serial, last, done}, 5'b10000);
        applyStimulus(1'b1, 16'h0001, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("0001 bit%0d", i), {valid, serial, last},
                        {1'b1, (i == 15), (i == 15)});
            step();
        end
        checkOutput("0001 done", {ready, valid, done}, 3'b001);
        step();

        // A load during done is ignored. A load in the next cycle is taken.
        applyStimulus(1'b1, 16'h1234, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        repeat (16) step();
        checkOutput("1234 done", {ready, valid, done}, 3'b001);
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        step();
        checkOutput("load in done ignored", {ready, valid, done}, 3'b100);
        applyStimulus(1'b1, 16'hC000, 1'b0);
        step();
        checkOutput("load after done taken", {ready, valid, serial}, 3'b011);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("c000 hold%0d", i), {valid, serial, last}, 3'b110);
        end
        bit_ack = 1'b1;
        step();
        checkOutput("c000 bit1", {valid, serial}, 2'b11);
        step();
        checkOutput("c000 bit2", {valid, serial}, 2'b10);
        repeat (14) step();
        checkOutput("c000 done", {valid, done}, 2'b01);
        step();

        // bit_ack while idle has no effect.
        applyStimulus(1'b0, 16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("idle ack%0d", i), {ready, valid, serial, last, done}, 5'b10000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
